// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose:
//   UART receiver. Deserialises an asynchronous, idle-high serial line into
//   DWIDTH-bit words (LSB first), checks the parity slot according to PARTYP
//   and checks the stop bit. All sampling is qualified by an external 16x
//   baud tick shared with the transmitter, so PARTYP semantics match the
//   transmit-side parity generator.
//
// Parameters:
//   DWIDTH  data bits per frame (>= 2)
//   PARTYP  2'b01 odd parity, 2'b10 even parity,
//           2'b00 / 2'b11 no parity: the parity slot is a second stop bit
//           that must be 1
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   baud_tick   in   one-clk pulse at 16x the baud rate
//   rx_in       in   raw serial line, asynchronous to clk
//   data_out    out  last received word, held until the next frame completes
//   data_valid  out  one-clk pulse when a frame completes (good or bad)
//   parity_err  out  parity / second-stop check failed for data_out
//   frame_err   out  stop bit sampled low for data_out
//   busy        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int          DWIDTH = 8,
    parameter logic [1:0]  PARTYP = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              rx_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(DWIDTH - 1);
    localparam logic [3:0]    START_MID  = 4'd7;
    localparam logic [3:0]    BIT_END    = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_armed;
    logic [3:0]         r_tick_cnt;
    logic [BW-1:0]      r_bit_cnt;
    logic [DWIDTH-1:0]  r_shift;
    logic               r_perr_pend;
    logic [DWIDTH-1:0]  r_data_out;
    logic               r_data_valid;
    logic               r_parity_err;
    logic               r_frame_err;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    state_t             w_state_next;
    logic               w_rx_s;
    logic               w_cnt_clr;
    logic               w_bit_clr;
    logic               w_shift_en;
    logic               w_par_en;
    logic               w_stop_en;
    logic               w_par_exp;

    assign w_rx_s = r_sync2;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser. Both flops reset to the idle level so that
    // reset release never looks like a start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Expected value of the parity slot, computed from the fully assembled
    // word (the shift register is complete by the time PARITY samples).
    // -----------------------------------------------------------------------
    always_comb begin
        case (PARTYP)
            2'b01:   w_par_exp = ~^r_shift;
            2'b10:   w_par_exp = ^r_shift;
            default: w_par_exp = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_stop_en    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_armed blocks a held-low line (break) from re-triggering
                // immediately after the frame it produced.
                if (baud_tick && !w_rx_s && r_armed) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end

            S_START: begin
                if (baud_tick && (r_tick_cnt == START_MID)) begin
                    if (w_rx_s) begin
                        // Line went back high before mid-start: glitch.
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_cnt_clr    = 1'b1;
                        w_bit_clr    = 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (baud_tick && (r_tick_cnt == BIT_END)) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (baud_tick && (r_tick_cnt == BIT_END)) begin
                    w_par_en     = 1'b1;
                    w_state_next = S_STOP;
                end
            end

            S_STOP: begin
                // Returning to IDLE at mid-stop leaves half a bit of margin
                // for a back-to-back start edge at the next bit boundary.
                if (baud_tick && (r_tick_cnt == BIT_END)) begin
                    w_stop_en    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Tick counter. Free-runs (wrapping 15 -> 0) on ticks outside IDLE, so
    // consecutive samples are exactly 16 ticks apart.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= 4'd0;
        end else if (w_cnt_clr) begin
            r_tick_cnt <= 4'd0;
        end else if (baud_tick && (r_state != S_IDLE)) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Bit counter and shift register. Bits arrive LSB first, so each new bit
    // enters at the MSB and the word settles into place after DWIDTH shifts.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DWIDTH-1:1]};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending parity error, cleared at the start of each frame's data phase.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr_pend <= 1'b0;
        end else if (w_bit_clr) begin
            r_perr_pend <= 1'b0;
        end else if (w_par_en) begin
            r_perr_pend <= (w_rx_s != w_par_exp);
        end
    end

    // -----------------------------------------------------------------------
    // Falling-edge qualifier: disarmed when a frame completes, re-armed once
    // the line is seen high while idle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b1;
        end else if (w_stop_en) begin
            r_armed <= 1'b0;
        end else if ((r_state == S_IDLE) && w_rx_s) begin
            r_armed <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers: updated only when a frame completes, so results and
    // flags persist across later start bits until the next delivery.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= w_stop_en;
            if (w_stop_en) begin
                r_data_out   <= r_shift;
                r_parity_err <= r_perr_pend;
                r_frame_err  <= ~w_rx_s;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Three receivers (even, odd and no parity) listen to the same serial line.
// Each frame driven pushes one expected result per receiver; a monitor per
// receiver pops and compares whenever data_valid pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_PER_TICK = 4;
    localparam int CLK_PER_BIT  = 16 * CLK_PER_TICK;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic baud_tick = 1'b0;
    logic rx_in     = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 16x baud tick: one clk high every CLK_PER_TICK clocks.
    initial begin
        forever begin
            repeat (CLK_PER_TICK - 1) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_dut
            logic [7:0] dout;
            logic       dv;
            logic       perr;
            logic       ferr;
            logic       bsy;
            logic       prev_dv;
            logic [9:0] exp_q [$];

            uart_rx #(
                .DWIDTH (8),
                .PARTYP ((gi == 0) ? 2'b10 : ((gi == 1) ? 2'b01 : 2'b00))
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .baud_tick  (baud_tick),
                .rx_in      (rx_in),
                .data_out   (dout),
                .data_valid (dv),
                .parity_err (perr),
                .frame_err  (ferr),
                .busy       (bsy)
            );

            always @(negedge clk) begin
                if (rst) begin
                    prev_dv <= 1'b0;
                end else begin
                    if (dv) begin
                        check_val($sformatf("dv_pulse%0d", gi), {31'd0, prev_dv}, 32'd0);
                        check_val($sformatf("busy_fall%0d", gi), {31'd0, bsy}, 32'd0);
                        if (exp_q.size() == 0) begin
                            check_val($sformatf("unexpected_dv%0d", gi), 32'd1, 32'd0);
                        end else begin
                            check_val($sformatf("data%0d", gi), {24'd0, dout}, {24'd0, exp_q[0][7:0]});
                            check_val($sformatf("ferr%0d", gi), {31'd0, ferr}, {31'd0, exp_q[0][8]});
                            check_val($sformatf("perr%0d", gi), {31'd0, perr}, {31'd0, exp_q[0][9]});
                            void'(exp_q.pop_front());
                        end
                    end
                    prev_dv <= dv;
                end
            end
        end
    endgenerate

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected result per receiver: {parity_err, frame_err, data}.
    task automatic push_exp(input logic [7:0] d, input logic pb, input logic sb);
        gen_dut[0].exp_q.push_back({(pb != (^d)),   ~sb, d});
        gen_dut[1].exp_q.push_back({(pb != (~^d)),  ~sb, d});
        gen_dut[2].exp_q.push_back({(pb != 1'b1),   ~sb, d});
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        wait_clk(CLK_PER_BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        push_exp(d, pb, sb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        wait_clk(n * CLK_PER_BIT);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dout0"}, {24'd0, gen_dut[0].dout}, 32'd0);
        check_val({tag, "_dout1"}, {24'd0, gen_dut[1].dout}, 32'd0);
        check_val({tag, "_dout2"}, {24'd0, gen_dut[2].dout}, 32'd0);
        check_val({tag, "_flags0"}, {28'd0, gen_dut[0].dv, gen_dut[0].perr, gen_dut[0].ferr, gen_dut[0].bsy}, 32'd0);
        check_val({tag, "_flags1"}, {28'd0, gen_dut[1].dv, gen_dut[1].perr, gen_dut[1].ferr, gen_dut[1].bsy}, 32'd0);
        check_val({tag, "_flags2"}, {28'd0, gen_dut[2].dv, gen_dut[2].perr, gen_dut[2].ferr, gen_dut[2].bsy}, 32'd0);
    endtask

    initial begin
        wait_clk(5);
        check_all_zero("reset");
        rst = 1'b0;
        idle_bits(2);

        // Parity cases across the three receivers.
        send_frame(8'hA5, 1'b0, 1'b1); idle_bits(2);
        send_frame(8'h3C, 1'b1, 1'b1); idle_bits(2);
        send_frame(8'h81, 1'b0, 1'b1); idle_bits(2);
        send_frame(8'h81, 1'b1, 1'b0); idle_bits(2);

        // False start: 4-tick low glitch.
        rx_in = 1'b0;
        wait_clk(12);
        check_val("glitch_busy_hi", {31'd0, gen_dut[0].bsy}, 32'd1);
        wait_clk(4);
        rx_in = 1'b1;
        wait_clk(40);
        check_val("glitch_busy_lo", {31'd0, gen_dut[0].bsy}, 32'd0);
        check_val("glitch_dout", {24'd0, gen_dut[0].dout}, 32'h81);
        check_val("glitch_ferr", {31'd0, gen_dut[0].ferr}, 32'd1);
        idle_bits(1);

        // Back-to-back frames, no idle gap.
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle_bits(2);

        // Break: line held low; exactly one framing-error frame, no re-arm.
        send_frame(8'h00, 1'b0, 1'b0);
        rx_in = 1'b0;
        wait_clk(24 * CLK_PER_BIT);
        check_val("break_no_rearm", {31'd0, gen_dut[0].bsy}, 32'd0);
        idle_bits(2);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_bits(2);

        // Reset in the middle of the data phase of 0xFF.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        wait_clk(10);
        rst = 1'b1;
        #2;
        check_all_zero("midrst");
        rx_in = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h12, 1'b0, 1'b1);
        idle_bits(2);

        wait_clk(100);
        check_val("q_left0", gen_dut[0].exp_q.size(), 32'd0);
        check_val("q_left1", gen_dut[1].exp_q.size(), 32'd0);
        check_val("q_left2", gen_dut[2].exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
